// File: rtl/mul_tc_sched.sv
// Issue scheduler sharing one pipelined 16x16 signed multiplier among N requesters.
// Define MUL_TC_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed top priority.

module mul_tc_sched_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic        ret_hit,
  input  logic [31:0] mul_p,
  input  logic        rsp_ready,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_p
);
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  // grant and rsp_hs are mutually exclusive: a pending result implies busy, and busy blocks grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
    end else begin
      if (grant)       busy <= 1'b1;
      else if (rsp_hs) busy <= 1'b0;
      if (ret_hit) begin
        rsp_valid <= 1'b1;
        rsp_p     <= mul_p;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

module mul_tc_sched #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [16*N-1:0] req_a,
  input  logic [16*N-1:0] req_b,
  output logic [15:0]     mul_a,
  output logic [15:0]     mul_b,
  output logic            mul_in_vld,
  input  logic [31:0]     mul_p,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [32*N-1:0] rsp_p,
  output logic [N-1:0]    busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]          elig, grant, ret_hit;
  logic                  gnt_vld;
  logic [IW-1:0]         gnt_idx;
  logic [N-1:0][15:0]    a_arr, b_arr;
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][IW-1:0]  id_pipe;

  assign a_arr = req_a;
  assign b_arr = req_b;
  assign elig  = req_valid & ~busy;

`ifdef MUL_TC_SCHED_RR_EN
  logic [IW-1:0] rr_ptr, rr_idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int k = 0; k < N; k++) begin
      rr_idx = IW'((int'(rr_ptr) + k) % N);
      if (!gnt_vld && elig[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (gnt_vld) rr_ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (elig[IW'(k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end
`endif

  assign grant     = gnt_vld ? (N'(1) << gnt_idx) : '0;
  assign req_ready = grant;

  // Stage 0 of the tag pipe is the issue register itself; stage LAT lines up with mul_p
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      if (gnt_vld) begin
        mul_a <= a_arr[gnt_idx];
        mul_b <= b_arr[gnt_idx];
      end
      vld_pipe <= {vld_pipe[LAT-1:0], gnt_vld};
      id_pipe  <= {id_pipe[LAT-1:0], gnt_idx};
    end
  end

  assign mul_in_vld = vld_pipe[0];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign ret_hit[i] = vld_pipe[LAT] && (id_pipe[LAT] == IW'(i));

    mul_tc_sched_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (grant[i]),
      .ret_hit   (ret_hit[i]),
      .mul_p     (mul_p),
      .rsp_ready (rsp_ready[i]),
      .busy      (busy[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_p     (rsp_p[32*i +: 32])
    );
  end
endmodule

// File: tb/tb_mul_tc_sched.sv
// Scoreboard bench for mul_tc_sched with a behavioural LAT-stage signed multiplier.
// Expected products come from a hand-computed vector table, queued per requester at issue.

module tb_mul_tc_sched;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [16*N-1:0] req_a, req_b;
  logic [15:0]     mul_a, mul_b;
  logic            mul_in_vld;
  logic [31:0]     mul_p;
  logic [32*N-1:0] rsp_p;

  mul_tc_sched #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_in_vld(mul_in_vld), .mul_p(mul_p), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] p_pipe [1:LAT];
  always @(posedge clk) begin
    p_pipe[1] <= $signed(mul_a) * $signed(mul_b);
    for (int k = 2; k <= LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_p = p_pipe[LAT];

  typedef struct { logic [15:0] a; logic [15:0] b; logic [31:0] exp; } vec_t;
  vec_t vec [8];

  int          jobs [N][$];
  logic [31:0] expq [N][$];
  int          gnt_log [$];
  int          gnt_cyc [$];
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (jobs[i].size() != 0);
      if (jobs[i].size() != 0) begin
        req_a[16*i +: 16] = vec[jobs[i][0]].a;
        req_b[16*i +: 16] = vec[jobs[i][0]].b;
      end
    end
  endtask

  function automatic bit all_idle();
    bit idle = (rsp_valid == '0);
    for (int i = 0; i < N; i++)
      if (jobs[i].size() != 0 || expq[i].size() != 0) idle = 0;
    return idle;
  endfunction

  task automatic drain(string nm);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      step();
      done = all_idle();
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  // Issue tracking: the expected product is queued the moment a request is accepted
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i] && jobs[i].size() != 0) begin
          expq[i].push_back(vec[jobs[i][0]].exp);
          void'(jobs[i].pop_front());
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc);
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          chk($sformatf("rsp_expected_r%0d", i), 32'(expq[i].size() != 0), 32'd1);
          if (expq[i].size() != 0)
            chk($sformatf("rsp_p_r%0d", i), rsp_p[32*i +: 32], expq[i].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    vec[0] = '{16'h0003, 16'hFFFB, 32'hFFFFFFF1};
    vec[1] = '{16'h8000, 16'h8000, 32'h40000000};
    vec[2] = '{16'h8000, 16'h7FFF, 32'hC0008000};
    vec[3] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vec[4] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vec[5] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vec[6] = '{16'h0064, 16'hFF38, 32'hFFFFB1E0};
    vec[7] = '{16'h04D2, 16'h162E, 32'h006AE9BC};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_mul_in_vld", 32'(mul_in_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 32'd0);
    chk("rst_rsp_p_lo", rsp_p[63:0] == '0, 32'd1);
    chk("rst_rsp_p_hi", rsp_p[127:64] == '0, 32'd1);
    rst_n = 1'b1;

    // All four continuously valid: 0,1,2,3 then each re-granted 5 cycles later
    s = gnt_log.size();
    for (int i = 0; i < N; i++) jobs[i] = '{i, i + 4};
    drain("drain_all4");
    chk("all4_count", 32'(gnt_log.size() - s), 32'd8);
    if (gnt_log.size() - s == 8)
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("all4_order_%0d", k), 32'(gnt_log[s+k]), 32'(k % 4));
        if (k >= 4) chk($sformatf("all4_regrant_%0d", k), 32'(gnt_cyc[s+k] - gnt_cyc[s+k-4]), 32'd5);
      end

    // Single op on requester 1: 3 x -5
    jobs[1] = '{0};
    step();
    @(negedge clk); chk("single_req_ready", 32'(req_ready), 32'h2);
    step();
    @(negedge clk);
    chk("single_mul_in_vld", 32'(mul_in_vld), 32'd1);
    chk("single_mul_ab", {mul_a, mul_b}, 32'h0003FFFB);
    chk("single_busy", 32'(busy), 32'h2);
    step(); @(negedge clk); chk("single_rsp_t2", 32'(rsp_valid), 32'd0);
    step(); @(negedge clk); chk("single_rsp_t3", 32'(rsp_valid), 32'd0);
    step(); @(negedge clk);
    chk("single_rsp_t4", 32'(rsp_valid), 32'h2);
    chk("single_rsp_p", rsp_p[63:32], 32'hFFFFFFF1);
    step(); @(negedge clk);
    chk("single_busy_clr", 32'(busy), 32'd0);
    chk("single_rsp_clr", 32'(rsp_valid), 32'd0);
    chk("single_rsp_hold", rsp_p[63:32], 32'hFFFFFFF1);

    // Contention after granting requester 1: pointer sits at 2
    s = gnt_log.size();
    jobs[0] = '{5}; jobs[2] = '{6};
    drain("drain_contend");
`ifdef MUL_TC_SCHED_RR_EN
    chk("contend_first", 32'(gnt_log[s]), 32'd2);
    chk("contend_second", 32'(gnt_log[s+1]), 32'd0);
`else
    chk("contend_first", 32'(gnt_log[s]), 32'd0);
    chk("contend_second", 32'(gnt_log[s+1]), 32'd2);
`endif

    // Corner products spread across requesters
    jobs[0] = '{1, 4}; jobs[1] = '{2}; jobs[2] = '{3, 7}; jobs[3] = '{0, 6};
    drain("drain_corner");

    // Backpressure on requester 2 must not stall the others
    rsp_ready = 4'b1011;
    jobs[2] = '{1, 2}; jobs[0] = '{4, 5}; jobs[1] = '{6, 7}; jobs[3] = '{3, 0};
    repeat (8) step();
    for (int k = 0; k < 20; k++) begin
      step(); @(negedge clk);
      chk("stall_rsp_valid2", 32'(rsp_valid[2]), 32'd1);
      chk("stall_rsp_p2", rsp_p[95:64], 32'h40000000);
      chk("stall_req_ready2", 32'(req_ready[2]), 32'd0);
    end
    chk("stall_others_done",
        32'(jobs[0].size() + jobs[1].size() + jobs[3].size() +
            expq[0].size() + expq[1].size() + expq[3].size()), 32'd0);
    rsp_ready = '1;
    drain("drain_stall");

    // Reset one cycle after mul_in_vld: the op is dropped, a fresh request is accepted at once
    jobs[3] = '{7};
    step();
    step(); @(negedge clk); chk("rmid_mul_in_vld", 32'(mul_in_vld), 32'd1);
    step();
    rst_n = 1'b0;
    expq[3].delete();
    jobs[3] = '{5};
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_mul_in_vld_clr", 32'(mul_in_vld), 32'd0);
    chk("rmid_req_ready", 32'(req_ready), 32'h8);
    drain("drain_rmid");
    repeat (4) step();

    chk("final_queues_empty", 32'(all_idle()), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_tc_sched.md
# mul_tc_sched

Shares one pipelined 16x16 two's-complement multiplier datapath (`mul_tc_16_16`: Booth partial products, the CSA tree and the final carry-propagate add) among N requesters. Each requester gets a valid/ready operand port and a valid/ready result port. The block arbitrates issue slots, drives the multiplier operands, and tracks which requester owns each in-flight operation. Each returning product is steered into a per-requester result register. The block sits between client logic and the multiplier instance; the multiplier itself stays outside it.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- LAT, 2, fixed multiplier latency in cycles from `mul_in_vld` to valid `mul_p` (>=1)

Ports (clock is `clk`; reset is `rst_n`, synchronous, active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N  operand request valid, bit i = requester i
- req_ready  out  N  request accepted this cycle (one-hot or zero)
- req_a  in  16*N  multiplicand, signed, slice [16i+15:16i]
- req_b  in  16*N  multiplier, signed, same slicing
- mul_a  out  16  operand A to multiplier (registered)
- mul_b  out  16  operand B to multiplier (registered)
- mul_in_vld  out  1  operands valid this cycle (registered)
- mul_p  in  32  product from multiplier, valid exactly LAT cycles after `mul_in_vld`
- rsp_valid  out  N  result valid per requester
- rsp_ready  in  N  result consumed per requester
- rsp_p  out  32*N  signed product, slice [32i+31:32i]
- busy  out  N  requester i has an op in flight or an unconsumed result

## Operation
- Per-requester `busy[i]` register:
  - set on request handshake (`req_valid[i] & req_ready[i]`).
  - cleared on response handshake (`rsp_valid[i] & rsp_ready[i]`).
  - Limits each requester to one outstanding op, so the result register can never overflow.
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`, using the registered `busy`.
- Arbitration grants at most one eligible requester per cycle.
  - `req_ready` is combinational from `req_valid` and state. It never depends on `req_a`/`req_b`.
  - `req_ready[i]` is 0 whenever `busy[i]` is 1, even if `req_valid[i]` is 1.
- On grant of requester g:
  - `mul_a`/`mul_b` are loaded from g's operand slices; `mul_in_vld` is 1 next cycle.
  - With no grant, `mul_in_vld` is 0 and `mul_a`/`mul_b` hold their values.
- Tag pipeline: a shift register of depth LAT carries {valid, id[$clog2(N)-1:0]} alongside the multiplier.
  - When the tag output is valid, `mul_p` is written into `rsp_p` slice id and `rsp_valid[id]` is set.
  - `rsp_valid[id]` clears on the response handshake.
- `rsp_p` slice holds its value after handshake until overwritten by that requester's next result.
- The product is passed through unmodified: full 32-bit two's-complement result, no saturation or rounding.
- Throughput: one issue per cycle across all requesters. A single requester issues at most once per round trip.

## Timing
- Request handshake at cycle T gives `mul_in_vld`=1 at T+1. `mul_p` is sampled at T+1+LAT. `rsp_valid` is 1 from T+2+LAT.
- With LAT=2 the minimum request-to-rsp_valid latency is 4 cycles.
- Response handshake at cycle R clears `busy` at R+1. The earliest re-grant of that requester is at R+1; the same-cycle re-grant is not allowed.
- `rsp_valid` holds until `rsp_ready`; backpressure on one requester never stalls the others.
- Reset values, applied at the first edge with `rst_n`=0:
  - `mul_in_vld`, `rsp_valid`, `busy`, and all tag valid bits are 0.
  - `mul_a`, `mul_b` and `rsp_p` are 0.
  - The round-robin pointer is 0.
- Reset mid-operation: in-flight tags are dropped and a `mul_p` arriving later is ignored. No `rsp_valid` is asserted for ops issued before reset.

## Configuration
- `MUL_TC_SCHED_RR_EN` defined:
  - round-robin arbitration. The pointer holds the index after the last grant.
  - The search starts at the pointer and wraps modulo N.
  - The pointer updates only on a grant.
- Not defined:
  - fixed priority, with requester 0 highest; no pointer register.
  - A continuously re-requesting low index can starve higher indices.

## Test plan
- Single op, LAT=2: requester 1 issues a=0x0003, b=0xFFFB (-5) at T -> `mul_in_vld` at T+1, `rsp_valid[1]` at T+4, `rsp_p` slice 1 = 0xFFFFFFF1.
- Corner products:
  - -32768 x -32768 -> 0x40000000.
  - -32768 x 32767 -> 0xC0008000.
  - 0 x -1 -> 0x00000000.
- All 4 requesters valid continuously with `MUL_TC_SCHED_RR_EN` and `rsp_ready`=all 1 -> grant order 0,1,2,3, each requester re-granted only after its response handshake plus 1 cycle. Without the macro, requester 0 wins every cycle it is eligible.
- `rsp_ready[2]` held 0 for 20 cycles -> `rsp_valid[2]` and `rsp_p` slice 2 stable, `req_ready[2]`=0 throughout, other requesters' results delivered normally.
- Reset asserted 1 cycle after `mul_in_vld` -> no `rsp_valid` ever rises for that op, `busy`=0 after reset, a fresh request is accepted on the first cycle with `rst_n`=1.
